// File: rtl/prog_loader_if.sv
// Program-memory byte write bus from the boot loader to the core's program RAM.
// Single-cycle write strobe with address and data; the memory cannot stall it.
interface prog_loader_if #(
  parameter int ADDR_W = 7
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/prog_loader.sv
// UART boot loader: receives A5/N/data/checksum frames and writes program memory, holding the core in reset.
// Write 1 cycle after each received byte; cpu_rst_n 1 cycle after the checksum byte; no backpressure (UART cannot stall).
module prog_loader #(
  parameter int CLK_FREQ     = 25000000,
  parameter int BAUD         = 115200,
  parameter int SIZE         = 128,
  parameter int ADDR_W       = 7,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          uart_rx,
  prog_loader_if.master mem,
  output logic          cpu_rst_n,
  output logic          load_done,
  output logic          load_err
);
  localparam int CPB     = CLK_FREQ / BAUD;
  localparam int HALF    = CPB / 2;
  localparam int CNT_W   = $clog2(CPB);
  localparam int TMO_CYC = TIMEOUT_BITS * CPB;
  localparam int TMO_W   = $clog2(TMO_CYC + 1);
  localparam int LEN_W   = $clog2(SIZE + 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN, L_DATA, L_CSUM, L_DONE} ld_state_t;

  // ---------------- RX engine ----------------
  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_st, rx_st_nxt;
  logic [CNT_W-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]       rx_idx, rx_idx_nxt;
  logic [7:0]       rx_shift, rx_shift_nxt;
  logic             byte_vld, byte_vld_nxt;
  logic             ferr, ferr_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st    <= R_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
      byte_vld <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_st    <= rx_st_nxt;
      rx_cnt   <= rx_cnt_nxt;
      rx_idx   <= rx_idx_nxt;
      rx_shift <= rx_shift_nxt;
      byte_vld <= byte_vld_nxt;
      ferr     <= ferr_nxt;
    end
  end

  // rx_shift holds the received byte stable while byte_vld is high.
  always_comb begin
    rx_st_nxt    = rx_st;
    rx_cnt_nxt   = rx_cnt + 1'b1;
    rx_idx_nxt   = rx_idx;
    rx_shift_nxt = rx_shift;
    byte_vld_nxt = 1'b0;
    ferr_nxt     = 1'b0;
    unique case (rx_st)
      R_IDLE: begin
        rx_cnt_nxt = '0;
        if (rx_prev && !rx_sync) rx_st_nxt = R_START;
      end
      R_START: begin
        if (rx_cnt == CNT_W'(HALF - 1)) begin
          rx_cnt_nxt = '0;
          rx_idx_nxt = '0;
          rx_st_nxt  = rx_sync ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt == CNT_W'(CPB - 1)) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_sync, rx_shift[7:1]};
          rx_idx_nxt   = rx_idx + 1'b1;
          if (rx_idx == 3'd7) rx_st_nxt = R_STOP;
        end
      end
      R_STOP: begin
        if (rx_cnt == CNT_W'(CPB - 1)) begin
          rx_cnt_nxt = '0;
          rx_st_nxt  = R_IDLE;
          if (rx_sync) byte_vld_nxt = 1'b1;
          else         ferr_nxt     = 1'b1;
        end
      end
      default: rx_st_nxt = R_IDLE;
    endcase
  end

  // ---------------- Loader FSM ----------------
  ld_state_t         st, st_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [7:0]        sum_q, sum_nxt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              we_q, we_nxt;
  logic [ADDR_W-1:0] maddr_q, maddr_nxt;
  logic [7:0]        wdat_q, wdat_nxt;
  logic              crst_q, crst_nxt;
  logic              done_q, done_nxt;
  logic              err_q, err_nxt;
  logic              tmo_active, tmo_hit, fail;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= L_IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdat_q  <= '0;
      crst_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      st      <= st_nxt;
      len_q   <= len_nxt;
      addr_q  <= addr_nxt;
      sum_q   <= sum_nxt;
      we_q    <= we_nxt;
      maddr_q <= maddr_nxt;
      wdat_q  <= wdat_nxt;
      crst_q  <= crst_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
    end
  end

  // A byte arriving on the last timeout cycle wins: it clears the counter instead of failing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       tmo_cnt <= '0;
    else if (!tmo_active || byte_vld || st_nxt != st) tmo_cnt <= '0;
    else                                            tmo_cnt <= tmo_cnt + 1'b1;
  end

  always_comb begin
    st_nxt     = st;
    len_nxt    = len_q;
    addr_nxt   = addr_q;
    sum_nxt    = sum_q;
    we_nxt     = 1'b0;
    maddr_nxt  = maddr_q;
    wdat_nxt   = wdat_q;
    crst_nxt   = crst_q;
    done_nxt   = done_q;
    err_nxt    = err_q;
    fail       = 1'b0;
    tmo_active = (st == L_LEN) || (st == L_DATA) || (st == L_CSUM);
    tmo_hit    = tmo_active && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    unique case (st)
      L_IDLE, L_DONE: begin
        if (byte_vld && rx_shift == SYNC_BYTE) begin
          st_nxt   = L_LEN;
          done_nxt = 1'b0;
          err_nxt  = 1'b0;
          crst_nxt = 1'b0;
          addr_nxt = '0;
          sum_nxt  = '0;
        end
      end
      L_LEN: begin
        if (byte_vld) begin
          if (rx_shift == 8'd0 || int'(rx_shift) > SIZE) begin
            fail = 1'b1;
          end else begin
            len_nxt = LEN_W'(rx_shift);
            st_nxt  = L_DATA;
          end
        end else if (ferr || tmo_hit) begin
          fail = 1'b1;
        end
      end
      L_DATA: begin
        if (byte_vld) begin
          we_nxt    = 1'b1;
          maddr_nxt = addr_q;
          wdat_nxt  = rx_shift;
          sum_nxt   = sum_q + rx_shift;
          if (LEN_W'(addr_q) + LEN_W'(1) == len_q) st_nxt   = L_CSUM;
          else                                     addr_nxt = addr_q + 1'b1;
        end else if (ferr || tmo_hit) begin
          fail = 1'b1;
        end
      end
      L_CSUM: begin
        if (byte_vld) begin
          if (rx_shift == sum_q) begin
            st_nxt   = L_DONE;
            crst_nxt = 1'b1;
            done_nxt = 1'b1;
          end else begin
            fail = 1'b1;
          end
        end else if (ferr || tmo_hit) begin
          fail = 1'b1;
        end
      end
      default: st_nxt = L_IDLE;
    endcase
    if (fail) begin
      st_nxt   = L_IDLE;
      err_nxt  = 1'b1;
      crst_nxt = 1'b0;
      done_nxt = 1'b0;
    end
  end

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = maddr_q;
  assign mem.mem_wdata = wdat_q;
  assign cpu_rst_n     = crst_q;
  assign load_done     = done_q;
  assign load_err      = err_q;
endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: drives UART frames (directed + random) and checks writes and status against a byte-level frame model.
module tb_prog_loader;
  localparam int CLK_FREQ     = 1000000;
  localparam int BAUD         = 100000;
  localparam int SIZE         = 128;
  localparam int ADDR_W       = 7;
  localparam int TIMEOUT_BITS = 64;
  localparam int CPB          = CLK_FREQ / BAUD;
  localparam int TMO          = TIMEOUT_BITS * CPB;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic uart_rx = 1'b1;
  logic cpu_rst_n, load_done, load_err;

  prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  prog_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .SIZE(SIZE), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .mem(bus),
    .cpu_rst_n(cpu_rst_n), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int wr_count = 0;
  logic [7:0] obs_mem [SIZE];

  typedef struct {int a; int d;} wr_t;
  wr_t exp_q[$];

  // Frame-level reference: where we are in the frame, plus expected status flags.
  typedef enum {P_IDLE, P_LEN, P_DATA, P_CSUM, P_DONE} phase_t;
  phase_t m_ph = P_IDLE;
  int m_len = 0, m_cnt = 0, m_sum = 0;
  int m_crst = 0, m_done = 0, m_err = 0;

  function automatic void chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void m_reset();
    m_ph = P_IDLE; m_crst = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic void m_error();
    m_ph = P_IDLE; m_err = 1; m_crst = 0; m_done = 0;
  endfunction

  function automatic void m_byte(input logic [7:0] b);
    wr_t w;
    case (m_ph)
      P_IDLE, P_DONE:
        if (b == 8'hA5) begin
          m_ph = P_LEN; m_done = 0; m_err = 0; m_crst = 0; m_cnt = 0; m_sum = 0;
        end
      P_LEN:
        if (b == 0 || int'(b) > SIZE) m_error();
        else begin m_len = int'(b); m_ph = P_DATA; end
      P_DATA: begin
        w.a = m_cnt; w.d = int'(b);
        exp_q.push_back(w);
        m_sum = (m_sum + int'(b)) % 256;
        m_cnt++;
        if (m_cnt == m_len) m_ph = P_CSUM;
      end
      P_CSUM:
        if (int'(b) == m_sum) begin m_ph = P_DONE; m_crst = 1; m_done = 1; end
        else m_error();
      default: m_ph = P_IDLE;
    endcase
  endfunction

  function automatic void m_abort();
    if (m_ph == P_LEN || m_ph == P_DATA || m_ph == P_CSUM) m_error();
  endfunction

  // Every write strobe is matched in order against the model's expected writes.
  always @(negedge clk) begin
    wr_t e;
    if (rst === 1'b1 && bus.mem_we === 1'b1) begin
      wr_count++;
      obs_mem[bus.mem_addr] = bus.mem_wdata;
      chk("write_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("write_addr", int'(bus.mem_addr), e.a);
        chk("write_data", int'(bus.mem_wdata), e.d);
      end
    end
  end

  task automatic check_status(input string tag);
    chk({tag, "_cpu_rst_n"}, int'(cpu_rst_n), m_crst);
    chk({tag, "_load_done"}, int'(load_done), m_done);
    chk({tag, "_load_err"},  int'(load_err),  m_err);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_ok) m_byte(b);
    else         m_abort();
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
    @(negedge clk);
    check_status("byte");
  endtask

  task automatic send_seq(input logic [7:0] q[$], input int gap_max);
    foreach (q[i]) begin
      send_byte(q[i]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) @(negedge clk);
    end
  endtask

  task automatic line_idle_timeout();
    repeat (TMO + 2 * CPB) @(negedge clk);
    m_abort();
    check_status("timeout");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mem_we",    int'(bus.mem_we),    0);
    chk("rst_mem_addr",  int'(bus.mem_addr),  0);
    chk("rst_mem_wdata", int'(bus.mem_wdata), 0);
    chk("rst_cpu_rst_n", int'(cpu_rst_n),     0);
    chk("rst_load_done", int'(load_done),     0);
    chk("rst_load_err",  int'(load_err),      0);
    chk("rst_pending_writes", exp_q.size(), 0);
    exp_q.delete();
    m_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_obs();
    foreach (obs_mem[i]) obs_mem[i] = 8'hEE;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] good[$];
    logic [7:0] badc[$];
    logic [7:0] q[$];
    logic [7:0] b;
    int w0, kind, n, s, cut;

    good = '{8'hA5, 8'h04, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
    badc = '{8'hA5, 8'h04, 8'h13, 8'h05, 8'h10, 8'h00, 8'h29};
    clear_obs();
    do_reset();

    // 1: basic load
    w0 = wr_count;
    send_seq(good, 0);
    chk("t1_writes", wr_count - w0, 4);
    chk("t1_mem0", int'(obs_mem[0]), 'h13);
    chk("t1_mem1", int'(obs_mem[1]), 'h05);
    chk("t1_mem2", int'(obs_mem[2]), 'h10);
    chk("t1_mem3", int'(obs_mem[3]), 'h00);
    chk("t1_cpu_rst_n", int'(cpu_rst_n), 1);
    chk("t1_load_done", int'(load_done), 1);
    chk("t1_load_err",  int'(load_err),  0);

    // 2: bad checksum, then recovery
    w0 = wr_count;
    send_seq(badc, 0);
    chk("t2_writes", wr_count - w0, 4);
    chk("t2_load_err", int'(load_err), 1);
    chk("t2_cpu_rst_n", int'(cpu_rst_n), 0);
    chk("t2_load_done", int'(load_done), 0);
    send_seq(good, 0);
    chk("t2_reload_done", int'(load_done), 1);
    chk("t2_reload_err",  int'(load_err),  0);

    // 3: junk bytes ignored, zero and oversized lengths
    q = '{8'h00, 8'hFF};
    send_seq(q, 0);
    chk("t3_junk_done", int'(load_done), 1);
    q = '{8'hA5, 8'h00};
    send_seq(q, 0);
    chk("t3_len0_err", int'(load_err), 1);
    w0 = wr_count;
    q = '{8'hA5, 8'h81};
    send_seq(q, 0);
    chk("t3_len129_err", int'(load_err), 1);
    chk("t3_len129_writes", wr_count - w0, 0);

    // 4: inter-byte timeout, then framing error mid-data
    w0 = wr_count;
    q = '{8'hA5, 8'h04, 8'h13, 8'h05};
    send_seq(q, 0);
    line_idle_timeout();
    chk("t4_tmo_err", int'(load_err), 1);
    chk("t4_tmo_writes", wr_count - w0, 2);
    send_seq(q, 0);
    send_byte(8'h10, 1'b0);
    chk("t4_ferr_err", int'(load_err), 1);

    // 5: reload over a finished image
    send_seq(good, 0);
    chk("t5_first_cpu_rst_n", int'(cpu_rst_n), 1);
    clear_obs();
    send_byte(8'hA5);
    chk("t5_sync_cpu_rst_n", int'(cpu_rst_n), 0);
    chk("t5_sync_load_done", int'(load_done), 0);
    q = '{8'h02, 8'hAA, 8'h55, 8'hFF};
    send_seq(q, 0);
    chk("t5_mem0", int'(obs_mem[0]), 'hAA);
    chk("t5_mem1", int'(obs_mem[1]), 'h55);
    chk("t5_cpu_rst_n", int'(cpu_rst_n), 1);

    // 6: reset mid-data, then a clean load; short glitch on the line
    q = '{8'hA5, 8'h04, 8'h13, 8'h05};
    send_seq(q, 0);
    do_reset();
    send_seq(good, 0);
    chk("t6_after_rst_done", int'(load_done), 1);
    send_byte(8'hA5);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    q = '{8'h04, 8'h13, 8'h05, 8'h10, 8'h00, 8'h28};
    send_seq(q, 0);
    chk("t6_glitch_done", int'(load_done), 1);
    chk("t6_glitch_err",  int'(load_err),  0);

    // Full-size image
    w0 = wr_count;
    q.delete();
    q.push_back(8'hA5);
    q.push_back(8'(SIZE));
    s = 0;
    for (int i = 0; i < SIZE; i++) begin
      b = 8'($urandom_range(0, 255));
      q.push_back(b);
      s = (s + int'(b)) % 256;
    end
    q.push_back(8'(s));
    send_seq(q, 0);
    chk("max_writes", wr_count - w0, SIZE);
    chk("max_done", int'(load_done), 1);

    // Random frames with junk, bad lengths, bad sums, framing errors and timeouts
    for (int it = 0; it < 20; it++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b);
      end
      kind = $urandom_range(0, 9);
      n = $urandom_range(1, 12);
      q.delete();
      q.push_back(8'hA5);
      if (kind == 0) begin
        q.push_back(($urandom_range(0, 1) == 1) ? 8'h00 : 8'($urandom_range(SIZE + 1, 255)));
        send_seq(q, 20);
      end else begin
        q.push_back(8'(n));
        s = 0;
        for (int i = 0; i < n; i++) begin
          b = 8'($urandom_range(0, 255));
          q.push_back(b);
          s = (s + int'(b)) % 256;
        end
        if (kind == 1) q.push_back(8'((s + int'($urandom_range(1, 255))) % 256));
        else           q.push_back(8'(s));
        if (kind == 2 || kind == 3) begin
          cut = $urandom_range(1, n + 2);
          for (int i = 0; i < cut; i++) begin
            send_byte(q[i]);
            repeat ($urandom_range(0, 20)) @(negedge clk);
          end
          if (kind == 2) send_byte(q[cut], 1'b0);
          else           line_idle_timeout();
        end else begin
          send_seq(q, 20);
        end
      end
    end

    repeat (20) @(negedge clk);
    chk("writes_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- UART boot loader sitting directly upstream of the KRV-32 core.
- Receives a firmware image over a serial line and writes it byte-by-byte into the core's program memory (byte-addressed, big-endian fetch order, addresses 0..SIZE-1).
- Holds the core in reset while loading. Releases it only after a complete image with a valid checksum has been written.

Parameters:
- CLK_FREQ, 25000000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated, must be at least 4.
- SIZE, 128, program memory size in bytes.
- ADDR_W, 7, program memory address width; 2**ADDR_W >= SIZE.
- TIMEOUT_BITS, 64, maximum idle gap between bytes inside a frame, in bit periods.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, reset, asynchronous, active-low.
- uart_rx, input, 1, serial input; idle high, asynchronous to clk.
- mem_we, output, 1, program memory byte write strobe; one-cycle pulse.
- mem_addr, output, ADDR_W, byte address for the write.
- mem_wdata, output, 8, byte to write.
- cpu_rst_n, output, 1, drives the core's rst; 0 holds the core in reset.
- load_done, output, 1, image loaded and verified.
- load_err, output, 1, last load attempt failed.

Behaviour:
- Reset (rst=0, asynchronous):
  - mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, load_done=0, load_err=0.
  - All FSMs go idle; counters and checksum are cleared.
  - Asserting reset mid-load aborts the load; bytes already written stay in memory.
- uart_rx synchroniser: two flops, reset value 1.
- RX engine:
  - A falling edge on the synchronised line starts a frame.
  - Start bit is re-sampled at CLKS_PER_BIT/2. If high, it is a false start: return to idle, no byte.
  - 8 data bits, LSB first, each sampled one CLKS_PER_BIT after the previous sample.
  - Stop bit is sampled once. If high, byte_valid pulses for one cycle. If low, it is a framing error: ferr pulses, no byte.
  - RX engine re-arms immediately after the stop-bit sample.
- Frame format: 0xA5 (sync), N (length), N data bytes, C (checksum). C = 8-bit sum mod 256 of the data bytes only.
- Loader FSM states: IDLE, LEN, DATA, CSUM, DONE.
  - IDLE:
    - Received 0xA5: load_done=0, load_err=0, cpu_rst_n=0, addr=0, sum=0; go to LEN.
    - Any other byte, or a framing error: ignored.
  - LEN:
    - N==0 or N>SIZE: error.
    - Otherwise latch N and go to DATA.
  - DATA, on each byte:
    - Cycle after byte_valid: mem_we=1 for exactly one cycle, mem_addr=addr, mem_wdata=byte.
    - sum += byte (mod 256), addr += 1.
    - After the Nth byte, go to CSUM.
    - addr never exceeds N-1, so there is no wrap.
  - CSUM:
    - C==sum: go to DONE, cpu_rst_n=1 and load_done=1 in the same cycle.
    - Otherwise: error.
  - DONE:
    - Outputs hold.
    - Received 0xA5: restart as in IDLE; cpu_rst_n drops to 0 the cycle after byte_valid.
    - Other bytes and framing errors: ignored.
  - Error (from LEN, DATA or CSUM):
    - load_err=1, sticky until the next accepted sync; cpu_rst_n=0, load_done=0; go to IDLE.
    - A framing error in LEN, DATA or CSUM is an error.
- Inter-byte timeout:
  - Active in LEN, DATA and CSUM.
  - Counter clears on every byte_valid and every state entry.
  - Reaching TIMEOUT_BITS*CLKS_PER_BIT cycles is an error.
- Latency:
  - mem_we occurs 1 cycle after byte_valid.
  - cpu_rst_n rises 1 cycle after the checksum byte's byte_valid.
- byte_valid and a timeout in the same cycle: the byte wins and the timeout counter clears.
- cpu_rst_n is registered and glitch-free.

Test Plan:
- Bench: CLK_FREQ=1000000, BAUD=100000 (10 clk/bit).
  1. After reset, send A5 04 13 05 10 00 28 -> mem_we pulses at addr 0..3 with 13,05,10,00; cpu_rst_n=1 and load_done=1 one cycle after the last byte; load_err=0.
  2. Same frame with checksum 29 -> four writes occur; load_err=1, cpu_rst_n=0, load_done=0; then a resend of the correct frame -> load_done=1, load_err=0.
  3. Send 00 FF A5 00 -> first two bytes ignored; length 0 gives load_err=1. Separately, A5 81 with SIZE=128 -> load_err=1 and no mem_we.
  4. A5 04 13 05, then line idle 640+ clocks -> load_err=1, exactly two writes. Separately, a stop bit forced low mid-DATA -> load_err=1.
  5. Complete a valid load (cpu_rst_n=1), then send A5 -> cpu_rst_n=0 one cycle after the sync byte; then a new 2-byte frame A5 02 AA 55 FF loads at addr 0,1 -> cpu_rst_n=1.
  6. Assert rst during the DATA byte stream -> all outputs return to reset values immediately; a subsequent full frame loads correctly. A 3-clock low glitch on idle uart_rx -> no byte_valid.
